ahb_sub_mem: RTL and testbench

//  AHB-Lite subordinate (responder) with an internal word-addressed memory: the far end of mux_out.

---
 rtl/ahb_sub_mem.sv | 81 ++++++++
 tb/tb_ahb_sub_mem.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ahb_sub_mem.sv
// ahb_sub_mem: AHB-Lite subordinate backed by a word-addressed memory,
// with programmable wait states and the two-cycle ERROR response.
module ahb_sub_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int AL = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AL-1:0] lane_q, lane_d;
  logic [2:0] size_q, size_d;
  logic write_q, write_d;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic acc, bad, done, take;
  logic [7:0] amask;
  logic [NB-1:0] be;
  logic unused_hburst;
  assign unused_hburst = ^HBURST;
  always_comb begin
    acc = HSEL & HREADY & HTRANS[1];
    amask = (8'd1 << HSIZE) - 8'd1;
    bad = ((HADDR >> AL) >= ADDR_WIDTH'(MEM_DEPTH)) | (HSIZE > 3'(AL)) | (|(HADDR[7:0] & amask));
    done = state_q == DATA && cnt_q == 4'd0;
    // a new address phase is only taken where this block is ready
    take = acc & (state_q == IDLE || state_q == ERR2 || done);
    state_d = state_q == ERR1 ? ERR2 :
              take ? (bad ? ERR1 : DATA) :
              (state_q == DATA && !done) ? DATA : IDLE;
    cnt_d = (take && !bad) ? 4'(WAIT_STATES) : (cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q);
    idx_d = take ? HADDR[AL +: IW] : idx_q;
    lane_d = take ? HADDR[AL-1:0] : lane_q;
    size_d = take ? HSIZE : size_q;
    write_d = take ? HWRITE : write_q;
    for (int i = 0; i < NB; i++) be[i] = ((lane_q ^ AL'(i)) >> size_q) == '0;
    HREADYOUT = state_q == ERR1 ? 1'b0 : state_q == DATA ? cnt_q == 4'd0 : 1'b1;
    HRESP = state_q == ERR1 || state_q == ERR2;
    HRDATA = (state_q == DATA && !write_q) ? mem[idx_q] : '0;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      lane_q <= '0;
      size_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      lane_q <= lane_d;
      size_q <= size_d;
      write_q <= write_d;
    end
  end
  always_ff @(posedge HCLK) begin
    if (done && write_q)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_sub_mem.sv
// tb_ahb_sub_mem: two subordinates (0 and 2 wait states) behind a simple
// select mux, checked against a byte-array reference model.
module tb_ahb_sub_mem;
  localparam int DEPTH = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic hsel0, hsel2, hwrite, dsel;
  logic [31:0] haddr, hwdata, rd0, rd2;
  logic [1:0] htrans;
  logic [2:0] hsize, hburst;
  logic ro0, ro2, rs0, rs2;
  wire hready = dsel ? ro2 : ro0;
  wire resp = dsel ? rs2 : rs0;
  wire [31:0] rdv = dsel ? rd2 : rd0;
  int checks = 0;
  int errors = 0;
  logic [7:0] refm [2][256];

  ahb_sub_mem #(.DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0));
  ahb_sub_mem #(.DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(2)) u2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(rd2), .HREADYOUT(ro2), .HRESP(rs2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refword(input int d, input int a);
    int b;
    b = a & ~3;
    return {refm[d][b+3], refm[d][b+2], refm[d][b+1], refm[d][b]};
  endfunction

  task automatic addr_phase(input int d, input logic w, input logic [2:0] sz, input logic [31:0] a);
    dsel = d[0];
    hsel0 = (d == 0);
    hsel2 = (d == 1);
    haddr = a;
    htrans = 2'd2;
    hwrite = w;
    hsize = sz;
    hburst = 3'($urandom);
  endtask

  task automatic idle_bus();
    hsel0 = 1'b0;
    hsel2 = 1'b0;
    htrans = 2'd0;
  endtask

  task automatic xfer(input int d, input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bit err;
    int waits;
    err = (a >> 2) >= DEPTH || sz > 2 || (a % (32'd1 << sz)) != 0;
    @(negedge clk);
    addr_phase(d, w, sz, a);
    @(negedge clk);
    idle_bus();
    hwdata = wd;
    if (err) begin
      chk("err1_ready", 32'(hready), 32'd0);
      chk("err1_resp", 32'(resp), 32'd1);
      @(negedge clk);
      chk("err2_ready", 32'(hready), 32'd1);
      chk("err2_resp", 32'(resp), 32'd1);
    end else begin
      waits = 0;
      while (!hready && waits < 40) begin
        chk("wait_resp", 32'(resp), 32'd0);
        waits++;
        @(negedge clk);
      end
      chk("wait_count", 32'(waits), d == 1 ? 32'd2 : 32'd0);
      chk("okay_resp", 32'(resp), 32'd0);
      if (!w) chk("rdata", rdv, refword(d, int'(a)));
      else for (int k = 0; k < (1 << sz); k++) refm[d][a+k] = wd[8*((a % 4) + k) +: 8];
    end
  endtask

  task automatic b2b(input int d, input logic [31:0] a, input logic [31:0] wd);
    int waits;
    @(negedge clk);
    addr_phase(d, 1'b1, 3'd2, a);
    @(negedge clk);
    hwdata = wd;
    addr_phase(d, 1'b0, 3'd2, a);
    waits = 0;
    while (!hready && waits < 40) begin waits++; @(negedge clk); end
    for (int k = 0; k < 4; k++) refm[d][a+k] = wd[8*k +: 8];
    @(negedge clk);
    idle_bus();
    waits = 0;
    while (!hready && waits < 40) begin waits++; @(negedge clk); end
    chk("b2b_waits", 32'(waits), d == 1 ? 32'd2 : 32'd0);
    chk("b2b_rdata", rdv, wd);
  endtask

  initial begin
    logic [31:0] a;
    dsel = 1'b0;
    idle_bus();
    haddr = '0;
    hwrite = 1'b0;
    hsize = 3'd2;
    hburst = '0;
    hwdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready0", 32'(ro0), 32'd1);
    chk("rst_resp0", 32'(rs0), 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_ready2", 32'(ro2), 32'd1);
    chk("rst_resp2", 32'(rs2), 32'd0);
    chk("rst_rdata2", rd2, 32'd0);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) xfer(d, 1'b1, 3'd2, 32'(4 * i), $urandom);
    xfer(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    xfer(0, 1'b0, 3'd2, 32'h10, 32'h0);
    chk("t1_rdata", rd0, 32'hDEADBEEF);
    xfer(1, 1'b0, 3'd2, 32'h0, 32'h0);
    xfer(0, 1'b1, 3'd2, 32'h10, 32'h11223344);
    xfer(0, 1'b1, 3'd0, 32'h13, 32'hAB000000);
    xfer(0, 1'b0, 3'd2, 32'h10, 32'h0);
    chk("t3_rdata", rd0, 32'hAB223344);
    xfer(0, 1'b0, 3'd2, 32'(4 * DEPTH), 32'h0);
    xfer(0, 1'b1, 3'd2, 32'(4 * DEPTH), 32'h55555555);
    xfer(0, 1'b1, 3'd1, 32'h11, 32'h66666666);
    xfer(0, 1'b1, 3'd3, 32'h10, 32'h77777777);
    xfer(0, 1'b0, 3'd2, 32'h0, 32'h0);
    xfer(0, 1'b0, 3'd2, 32'h10, 32'h0);
    b2b(0, 32'h24, 32'h0BADF00D);
    b2b(1, 32'h28, 32'h12345678);
    @(negedge clk);
    addr_phase(1, 1'b1, 3'd2, 32'h20);
    @(negedge clk);
    idle_bus();
    hwdata = 32'hCAFEF00D;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ro2), 32'd1);
    chk("midrst_resp", 32'(rs2), 32'd0);
    chk("midrst_rdata", rd2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 1'b0, 3'd2, 32'h20, 32'h0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 80; i++) begin
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 7) == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 1023));
        xfer(d, 1'($urandom), 3'($urandom_range(0, 3)), a, $urandom);
      end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
